// File: rtl/axi_rd_arbiter_if.sv
// Shared AXI4 read-channel bundle between the read engines and the SNAP core.
// slave is the arbiter view, master is the view of whatever drives it.
interface axi_rd_arbiter_if #(
    parameter int NUM_REQ      = 2,
    parameter int SEL_WIDTH    = 1,
    parameter int REQ_ID_WIDTH = 4,
    parameter int ID_WIDTH     = 5,
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 1024
);
    logic [NUM_REQ*REQ_ID_WIDTH-1:0] s_arid;
    logic [NUM_REQ*ADDR_WIDTH-1:0]   s_araddr;
    logic [NUM_REQ*8-1:0]            s_arlen;
    logic [NUM_REQ-1:0]              s_arvalid;
    logic [NUM_REQ-1:0]              s_arready;
    logic [REQ_ID_WIDTH-1:0]         s_rid;
    logic [DATA_WIDTH-1:0]           s_rdata;
    logic [1:0]                      s_rresp;
    logic                            s_rlast;
    logic [NUM_REQ-1:0]              s_rvalid;
    logic [NUM_REQ-1:0]              s_rready;

    logic [ID_WIDTH-1:0]             m_axi_arid;
    logic [ADDR_WIDTH-1:0]           m_axi_araddr;
    logic [7:0]                      m_axi_arlen;
    logic                            m_axi_arvalid;
    logic                            m_axi_arready;
    logic [ID_WIDTH-1:0]             m_axi_rid;
    logic [DATA_WIDTH-1:0]           m_axi_rdata;
    logic [1:0]                      m_axi_rresp;
    logic                            m_axi_rlast;
    logic                            m_axi_rvalid;
    logic                            m_axi_rready;

    modport slave (
        input  s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
        input  m_axi_arready, m_axi_rid, m_axi_rdata,
        input  m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output m_axi_arid, m_axi_araddr, m_axi_arlen,
        output m_axi_arvalid, m_axi_rready
    );

    modport master (
        output s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
        output m_axi_arready, m_axi_rid, m_axi_rdata,
        output m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen,
        input  m_axi_arvalid, m_axi_rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin AR arbiter with ID-prefix routing of R beats back to
// the owning read engine and a per-engine outstanding-burst limit.
module axi_rd_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int SEL_WIDTH       = 1,
    parameter int REQ_ID_WIDTH    = 4,
    parameter int ID_WIDTH        = 5,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 1024,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic             clk,
    input  logic             rst,
    axi_rd_arbiter_if.slave  bus,
    output logic             busy,
    output logic             err_unexpected_r
);
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q [NUM_REQ];
    logic [3:0]              cnt_d [NUM_REQ];
    logic [SEL_WIDTH-1:0]    last_grant_q, last_grant_d;
    logic [ID_WIDTH-1:0]     arid_q, arid_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic                    arvalid_q, arvalid_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic [NUM_REQ-1:0]      elig;
    logic [NUM_REQ-1:0]      ar_hs;
    logic [NUM_REQ-1:0]      r_done;
    logic [SEL_WIDTH-1:0]    winner;
    logic                    found;
    logic [REQ_ID_WIDTH-1:0] win_id;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [7:0]              win_len;
    logic [SEL_WIDTH-1:0]    sel;
    logic                    sel_ok;
    logic                    any_cnt;
    int                      idx;

    assign sel    = bus.m_axi_rid[ID_WIDTH-1:REQ_ID_WIDTH];
    assign sel_ok = int'(sel) < NUM_REQ;

    assign bus.s_rid   = bus.m_axi_rid[REQ_ID_WIDTH-1:0];
    assign bus.s_rdata = bus.m_axi_rdata[DATA_WIDTH-1:0];
    assign bus.s_rresp = bus.m_axi_rresp;
    assign bus.s_rlast = bus.m_axi_rlast;

    assign bus.m_axi_arid    = arid_q;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arvalid = arvalid_q;
    assign busy              = busy_q;
    assign err_unexpected_r  = err_q;

    // A requester may compete only while it has burst credit left
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.s_arvalid[i]
                   && (cnt_q[i] < 4'(MAX_OUTSTANDING));
        end
    end

    // Round-robin search starting just after the last grant
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_id   = '0;
        win_addr = '0;
        win_len  = '0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                found    = 1'b1;
                winner   = SEL_WIDTH'(idx);
                win_id   = bus.s_arid[idx*REQ_ID_WIDTH +: REQ_ID_WIDTH];
                win_addr = bus.s_araddr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                win_len  = bus.s_arlen[idx*8 +: 8];
            end
        end
    end

    // Steer each R beat to the requester named by the RID prefix
    always_comb begin
        bus.s_rvalid     = '0;
        bus.m_axi_rready = !sel_ok;
        r_done           = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_ok && int'(sel) == i) begin
                bus.s_rvalid[i]  = bus.m_axi_rvalid;
                bus.m_axi_rready = bus.s_rready[i];
                r_done[i]        = bus.m_axi_rvalid
                                && bus.s_rready[i]
                                && bus.m_axi_rlast;
            end
        end
    end

    // AR FSM: accept one request in IDLE, hold it on the master in ISSUE
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        arid_d        = arid_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        arvalid_d     = arvalid_q;
        ar_hs         = '0;
        bus.s_arready = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    ar_hs         = NUM_REQ'(1) << winner;
                    bus.s_arready = ar_hs;
                    arid_d        = {winner, win_id};
                    araddr_d      = win_addr;
                    arlen_d       = win_len;
                    arvalid_d     = 1'b1;
                    last_grant_d  = winner;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outstanding-burst accounting, error detection and busy
    always_comb begin
        err_d   = err_q;
        any_cnt = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (r_done[i] && cnt_q[i] == 4'd0) begin
                err_d = 1'b1;
            end
            if (ar_hs[i] && !r_done[i]) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end else if (!ar_hs[i] && r_done[i]
                         && cnt_q[i] != 4'd0) begin
                cnt_d[i] = cnt_q[i] - 4'd1;
            end
            if (cnt_d[i] != 4'd0) begin
                any_cnt = 1'b1;
            end
        end
        if (bus.m_axi_rvalid && !sel_ok) begin
            err_d = 1'b1;
        end
        busy_d = (state_d == ISSUE) || any_cnt;
    end

    // State and register update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= SEL_WIDTH'(NUM_REQ - 1);
            arid_q       <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            arid_q       <= arid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with NUM_REQ=2.
// Inputs change on the falling edge; outputs are sampled there or #1 later.
module tb_axi_rd_arbiter;
    logic clk;
    logic rst;
    logic busy;
    logic err_unexpected_r;
    int   checks;
    int   failures;

    axi_rd_arbiter_if #(
        .NUM_REQ(2), .SEL_WIDTH(1), .REQ_ID_WIDTH(4),
        .ID_WIDTH(5), .ADDR_WIDTH(64), .DATA_WIDTH(1024)
    ) bus ();

    axi_rd_arbiter #(
        .NUM_REQ(2), .SEL_WIDTH(1), .REQ_ID_WIDTH(4),
        .ID_WIDTH(5), .ADDR_WIDTH(64), .DATA_WIDTH(1024),
        .MAX_OUTSTANDING(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .err_unexpected_r(err_unexpected_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task clear_inputs;
        bus.s_arid        = '0;
        bus.s_araddr      = '0;
        bus.s_arlen       = '0;
        bus.s_arvalid     = '0;
        bus.s_rready      = '0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rid     = '0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = '0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
    endtask

    task clear_r;
        bus.m_axi_rid    = '0;
        bus.m_axi_rlast  = 1'b0;
        bus.m_axi_rvalid = 1'b0;
        bus.s_rready     = '0;
    endtask

    task do_reset;
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task test_reset;
        do_reset();
        #1;
        checks++;
        if (bus.m_axi_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_arvalid got=%b exp=0", bus.m_axi_arvalid);
        end
        checks++;
        if (bus.m_axi_arid !== 5'h00 || bus.m_axi_araddr !== 64'h0
            || bus.m_axi_arlen !== 8'h0) begin
            failures++;
            $display("FAIL reset_ar_fields got id=%h addr=%h len=%h exp=0",
                     bus.m_axi_arid, bus.m_axi_araddr, bus.m_axi_arlen);
        end
        checks++;
        if (busy !== 1'b0 || err_unexpected_r !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%b err=%b exp=0,0",
                     busy, err_unexpected_r);
        end
        bus.s_arvalid = 2'b11;
        #1;
        checks++;
        if (bus.s_arready !== 2'b01) begin
            failures++;
            $display("FAIL reset_first_grant got=%b exp=01", bus.s_arready);
        end
        bus.s_arvalid = 2'b00;
    endtask

    task test_alternate;
        logic [1:0] exp_rdy;
        logic [4:0] exp_id;
        do_reset();
        bus.s_arid        = {4'h2, 4'h2};
        bus.s_arvalid     = 2'b11;
        bus.m_axi_arready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            exp_rdy = (g % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (bus.s_arready !== exp_rdy || bus.m_axi_arvalid !== 1'b0) begin
                failures++;
                $display("FAIL alt_idle_%0d got rdy=%b arvalid=%b exp rdy=%b arvalid=0",
                         g, bus.s_arready, bus.m_axi_arvalid, exp_rdy);
            end
            @(negedge clk);
            exp_id = (g % 2 == 0) ? 5'h02 : 5'h12;
            checks++;
            if (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_arid !== exp_id
                || bus.s_arready !== 2'b00) begin
                failures++;
                $display("FAIL alt_issue_%0d got v=%b id=%h rdy=%b exp v=1 id=%h rdy=00",
                         g, bus.m_axi_arvalid, bus.m_axi_arid, bus.s_arready, exp_id);
            end
            @(negedge clk);
        end
        bus.s_arvalid = 2'b00;
    endtask

    task test_backpressure;
        do_reset();
        bus.s_arvalid     = 2'b10;
        bus.s_arid        = {4'h5, 4'h0};
        bus.s_araddr      = {64'h1000, 64'h0};
        bus.s_arlen       = {8'd3, 8'd0};
        bus.m_axi_arready = 1'b0;
        #1;
        checks++;
        if (bus.s_arready !== 2'b10) begin
            failures++;
            $display("FAIL bp_grant got=%b exp=10", bus.s_arready);
        end
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_araddr !== 64'h1000
                || bus.s_arready !== 2'b00 || bus.m_axi_arid !== 5'h15
                || bus.m_axi_arlen !== 8'd3) begin
                failures++;
                $display("FAIL bp_hold_%0d got v=%b addr=%h rdy=%b id=%h len=%0d exp v=1 addr=1000 rdy=00 id=15 len=3",
                         c, bus.m_axi_arvalid, bus.m_axi_araddr,
                         bus.s_arready, bus.m_axi_arid, bus.m_axi_arlen);
            end
            if (c == 4) bus.m_axi_arready = 1'b1;
            @(negedge clk);
        end
        #1;
        checks++;
        if (bus.m_axi_arvalid !== 1'b0 || bus.s_arready !== 2'b10) begin
            failures++;
            $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=10",
                     bus.m_axi_arvalid, bus.s_arready);
        end
        bus.s_arvalid = 2'b00;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_busy got=%b exp=1", busy);
        end
    endtask

    task test_outstanding;
        do_reset();
        bus.s_arvalid     = 2'b01;
        bus.m_axi_arready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            #1;
            checks++;
            if (bus.s_arready !== 2'b01) begin
                failures++;
                $display("FAIL outst_grant_%0d got=%b exp=01", b, bus.s_arready);
            end
            @(negedge clk);
            @(negedge clk);
        end
        #1;
        checks++;
        if (bus.s_arready !== 2'b00) begin
            failures++;
            $display("FAIL outst_block got=%b exp=00", bus.s_arready);
        end
        bus.s_arvalid = 2'b11;
        #1;
        checks++;
        if (bus.s_arready !== 2'b10) begin
            failures++;
            $display("FAIL outst_other got=%b exp=10", bus.s_arready);
        end
        @(negedge clk);
        bus.s_arvalid    = 2'b01;
        bus.m_axi_rid    = 5'h00;
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rlast  = 1'b1;
        bus.s_rready     = 2'b01;
        #1;
        checks++;
        if (bus.m_axi_rready !== 1'b1 || bus.s_rvalid !== 2'b01) begin
            failures++;
            $display("FAIL outst_rbeat got rready=%b rvalid=%b exp 1,01",
                     bus.m_axi_rready, bus.s_rvalid);
        end
        @(negedge clk);
        clear_r();
        #1;
        checks++;
        if (bus.s_arready !== 2'b01) begin
            failures++;
            $display("FAIL outst_regrant got=%b exp=01", bus.s_arready);
        end
        bus.s_arvalid = 2'b00;
    endtask

    task test_routing;
        do_reset();
        bus.m_axi_rid    = 5'h13;
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = 1024'hABCD_1234;
        bus.m_axi_rresp  = 2'b10;
        bus.s_rready     = 2'b01;
        #1;
        checks++;
        if (bus.s_rvalid !== 2'b10 || bus.s_rid !== 4'h3
            || bus.m_axi_rready !== 1'b0) begin
            failures++;
            $display("FAIL route_req1 got rvalid=%b rid=%h rready=%b exp 10,3,0",
                     bus.s_rvalid, bus.s_rid, bus.m_axi_rready);
        end
        checks++;
        if (bus.s_rdata[31:0] !== 32'hABCD_1234 || bus.s_rresp !== 2'b10) begin
            failures++;
            $display("FAIL route_bcast got data=%h resp=%b exp abcd1234,10",
                     bus.s_rdata[31:0], bus.s_rresp);
        end
        bus.s_rready = 2'b11;
        #1;
        checks++;
        if (bus.m_axi_rready !== 1'b1) begin
            failures++;
            $display("FAIL route_ready got=%b exp=1", bus.m_axi_rready);
        end
        bus.m_axi_rid = 5'h05;
        bus.s_rready  = 2'b10;
        #1;
        checks++;
        if (bus.s_rvalid !== 2'b01 || bus.s_rid !== 4'h5
            || bus.m_axi_rready !== 1'b0) begin
            failures++;
            $display("FAIL route_req0 got rvalid=%b rid=%h rready=%b exp 01,5,0",
                     bus.s_rvalid, bus.s_rid, bus.m_axi_rready);
        end
        clear_r();
        #1;
        checks++;
        if (bus.s_rvalid !== 2'b00 || err_unexpected_r !== 1'b0) begin
            failures++;
            $display("FAIL route_idle got rvalid=%b err=%b exp 00,0",
                     bus.s_rvalid, err_unexpected_r);
        end
    endtask

    task test_simultaneous;
        do_reset();
        bus.s_arvalid     = 2'b01;
        bus.m_axi_arready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            @(negedge clk);
        end
        bus.m_axi_rid    = 5'h00;
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rlast  = 1'b1;
        bus.s_rready     = 2'b01;
        #1;
        checks++;
        if (bus.s_arready !== 2'b01 || bus.m_axi_rready !== 1'b1) begin
            failures++;
            $display("FAIL simul_both got rdy=%b rready=%b exp 01,1",
                     bus.s_arready, bus.m_axi_rready);
        end
        @(negedge clk);
        bus.s_arvalid = 2'b00;
        clear_r();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL simul_busy_%0d got=%b exp=1", d, busy);
            end
            bus.m_axi_rid    = 5'h00;
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rlast  = 1'b1;
            bus.s_rready     = 2'b01;
            @(negedge clk);
            clear_r();
        end
        #1;
        checks++;
        if (busy !== 1'b0 || err_unexpected_r !== 1'b0) begin
            failures++;
            $display("FAIL simul_drain got busy=%b err=%b exp 0,0",
                     busy, err_unexpected_r);
        end
    endtask

    task test_errors;
        do_reset();
        bus.m_axi_rid    = 5'h10;
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rlast  = 1'b1;
        bus.s_rready     = 2'b10;
        @(negedge clk);
        clear_r();
        #1;
        checks++;
        if (err_unexpected_r !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_set got err=%b busy=%b exp 1,0",
                     err_unexpected_r, busy);
        end
        bus.s_arvalid     = 2'b01;
        bus.m_axi_arready = 1'b1;
        @(negedge clk);
        bus.s_arvalid    = 2'b00;
        @(negedge clk);
        bus.m_axi_rid    = 5'h00;
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rlast  = 1'b1;
        bus.s_rready     = 2'b01;
        @(negedge clk);
        clear_r();
        #1;
        checks++;
        if (err_unexpected_r !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_sticky got err=%b busy=%b exp 1,0",
                     err_unexpected_r, busy);
        end
        bus.s_arvalid     = 2'b01;
        bus.m_axi_arready = 1'b0;
        @(negedge clk);
        bus.s_arvalid = 2'b00;
        #1;
        checks++;
        if (bus.m_axi_arvalid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL err_issue got v=%b busy=%b exp 1,1",
                     bus.m_axi_arvalid, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.m_axi_arvalid !== 1'b0 || busy !== 1'b0
            || err_unexpected_r !== 1'b0) begin
            failures++;
            $display("FAIL err_midreset got v=%b busy=%b err=%b exp 0,0,0",
                     bus.m_axi_arvalid, busy, err_unexpected_r);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_alternate();
        test_backpressure();
        test_outstanding();
        test_routing();
        test_simultaneous();
        test_errors();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
